iob_timer_poller: RTL and testbench
===================================

IOB_TIMER_POLLER -- requirements
Module: iob_timer_poller

Interface
REQ-001 Parameter ADDR_W, default 16: native bus address width.
REQ-002 Parameter DATA_W, default 32: native bus data width; the timestamp is 2*DATA_W bits.
REQ-003 Parameters ENABLE_ADDR/SAMPLE_ADDR/LOW_ADDR/HIGH_ADDR, defaults 1/2/3/4: word addresses of the timer's TIMER_ENABLE, TIMER_SAMPLE, TIMER_DATA_LOW and TIMER_DATA_HIGH registers.
REQ-004 Parameter PERIOD_W, default 16: width of the auto-poll period counter.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 trigger  in  1  request one timestamp capture; a one-cycle pulse suffices.
REQ-008 valid  out  1  native master request.
REQ-009 address  out  ADDR_W  native master word address.
REQ-010 wdata  out  DATA_W  native master write data.
REQ-011 wstrb  out  DATA_W/8  native master write strobes; all zeros = read.
REQ-012 rdata  in  DATA_W  native read data, sampled in the cycle ready=1.
REQ-013 ready  in  1  native transfer completion.
REQ-014 timestamp  out  2*DATA_W  last captured timer value, {HIGH,LOW}.
REQ-015 ts_valid  out  1  one-cycle pulse when timestamp updates.
REQ-016 busy  out  1  high while any bus sequence is in progress.

Function
REQ-017 Bus rule: valid, address, wdata and wstrb stay constant from valid rise until the cycle ready=1; valid drops the cycle after; one outstanding transfer; ready while valid=0 ignored.
REQ-018 States: INIT, IDLE, SMP_SET, SMP_CLR, RD_LO, RD_HI, DONE.
REQ-019 INIT: write 1 to ENABLE_ADDR (wstrb all ones); on ready -> IDLE.
REQ-020 IDLE: busy=0, valid=0; pending request -> SMP_SET.
REQ-021 SMP_SET writes 1 to SAMPLE_ADDR, SMP_CLR writes 0 to SAMPLE_ADDR, RD_LO reads LOW_ADDR, RD_HI reads HIGH_ADDR; each advances on ready.
REQ-022 RD_LO holds rdata in an internal low register; RD_HI completion loads timestamp={rdata,low} and -> DONE.
REQ-023 DONE: ts_valid=1 for exactly one cycle, -> IDLE; minimum trigger-to-ts_valid latency with ready=1 every cycle: 9 cycles.
REQ-024 A trigger in any non-IDLE state sets a single pending flag (further triggers coalesce); pending cleared on entering SMP_SET.
REQ-025 trigger in IDLE enters SMP_SET the next cycle; trigger during INIT is held pending.
REQ-026 ready held at 0 stalls indefinitely; no timeout.
REQ-027 timestamp changes only at RD_HI completion; holds otherwise.

Reset
REQ-028 On rst: state=INIT, valid=0, address=0, wdata=0, wstrb=0, timestamp=0, ts_valid=0, busy=1, pending=0, period counter=0.
REQ-029 rst mid-transfer aborts immediately; the sequence restarts at INIT after release.

Configuration
REQ-030 Macro TIMER_POLLER_PERIODIC_EN defined: adds input period (PERIOD_W); in IDLE a counter increments each cycle and, on reaching period-1 with period!=0, raises an internal trigger and clears; counter held at 0 outside IDLE; period=0 disables auto-poll.
REQ-031 Macro undefined: no period port, no counter; captures occur only on trigger.

Structure
REQ-032 Shared package iob_timer_poller_pkg holds the state encoding constants and the default register address constants.
REQ-033 One sub-module, iob_nat_master_port: registers valid/address/wdata/wstrb and generates the transfer-done strobe; the FSM lives in the top.

Verification
REQ-034 Reset release, ready=1 always -> first transfer write 0x1 to address 1, then IDLE with busy=0.
REQ-035 trigger pulse; responder returns LOW=0xDEADBEEF, HIGH=0x00000012 -> writes 1 then 0 to address 2, reads 3 then 4, timestamp=0x00000012DEADBEEF, ts_valid one cycle.
REQ-036 Responder inserts 3 wait cycles per transfer -> request fields stable throughout each wait, ts_valid 21 cycles after trigger.
REQ-037 Three triggers during an active sequence -> exactly one additional sequence follows.
REQ-038 rst asserted during RD_LO -> valid=0 and timestamp=0 immediately; INIT write reissued after release.
REQ-039 TIMER_POLLER_PERIODIC_EN, period=20, ready=1 -> ts_valid pulses every 29 cycles; period=0 -> no capture without trigger.

Source files
------------

// File: rtl/iob_timer_poller_pkg.sv
// Shared definitions for the timer poller: the FSM state encoding and the
// default word addresses of the timer's registers.
package iob_timer_poller_pkg;

    // Polling sequence states
    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_SMP_SET = 3'd2,
        ST_SMP_CLR = 3'd3,
        ST_RD_LO   = 3'd4,
        ST_RD_HI   = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    // Default word addresses of the timer peripheral registers
    localparam int unsigned DEF_ENABLE_ADDR = 1;
    localparam int unsigned DEF_SAMPLE_ADDR = 2;
    localparam int unsigned DEF_LOW_ADDR    = 3;
    localparam int unsigned DEF_HIGH_ADDR   = 4;

    // States that own a bus transfer
    function automatic logic is_bus_state(input state_t s);
        return (s == ST_INIT) || (s == ST_SMP_SET) || (s == ST_SMP_CLR) ||
               (s == ST_RD_LO) || (s == ST_RD_HI);
    endfunction

endpackage

// File: rtl/iob_timer_poller_nat_master.sv
// Native bus master port: latches one request into the registered
// valid/address/wdata/wstrb outputs and holds them until ready, then drops
// valid the following cycle. New requests are ignored while a transfer is
// outstanding.
module iob_nat_master_port #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic [ADDR_W-1:0]   req_address,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                valid,
    output logic [ADDR_W-1:0]   address,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    input  logic                ready,
    output logic                done
);

    // Request register: load on req when free, release on ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid   <= 1'b0;
            address <= '0;
            wdata   <= '0;
            wstrb   <= '0;
        end else if (valid) begin
            if (ready) begin
                valid <= 1'b0;
            end
        end else if (req) begin
            valid   <= 1'b1;
            address <= req_address;
            wdata   <= req_wdata;
            wstrb   <= req_wstrb;
        end
    end

    // Transfer completes in the cycle ready meets an outstanding valid
    assign done = valid & ready;

endmodule

// File: rtl/iob_timer_poller.sv
// Timer poller: enables a timer peripheral after reset, then on each trigger
// pulses its SAMPLE register and reads the LOW/HIGH halves into timestamp.
// Optional macro TIMER_POLLER_PERIODIC_EN adds a period input that raises an
// internal trigger after 'period' idle cycles (period=0 disables it).
module iob_timer_poller
    import iob_timer_poller_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ENABLE_ADDR = DEF_ENABLE_ADDR,
    parameter int unsigned SAMPLE_ADDR = DEF_SAMPLE_ADDR,
    parameter int unsigned LOW_ADDR    = DEF_LOW_ADDR,
    parameter int unsigned HIGH_ADDR   = DEF_HIGH_ADDR,
    parameter int unsigned PERIOD_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
`ifdef TIMER_POLLER_PERIODIC_EN
    input  logic [PERIOD_W-1:0] period,
`endif
    input  logic                trigger,
    output logic                valid,
    output logic [ADDR_W-1:0]   address,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    input  logic [DATA_W-1:0]   rdata,
    input  logic                ready,
    output logic [2*DATA_W-1:0] timestamp,
    output logic                ts_valid,
    output logic                busy
);

    localparam int unsigned STRB_W = DATA_W / 8;

    state_t              state;
    state_t              next_state;
    logic                pending;
    logic                auto_trig;
    logic                done;
    logic [DATA_W-1:0]   low_reg;

    logic                req;
    logic [ADDR_W-1:0]   req_address;
    logic [DATA_W-1:0]   req_wdata;
    logic [STRB_W-1:0]   req_wstrb;

    iob_nat_master_port #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_port (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_address (req_address),
        .req_wdata   (req_wdata),
        .req_wstrb   (req_wstrb),
        .valid       (valid),
        .address     (address),
        .wdata       (wdata),
        .wstrb       (wstrb),
        .ready       (ready),
        .done        (done)
    );

`ifdef TIMER_POLLER_PERIODIC_EN
    logic [PERIOD_W-1:0] period_cnt;

    assign auto_trig = (state == ST_IDLE) && (period != '0) &&
                       (period_cnt == period - PERIOD_W'(1));

    // Idle-cycle counter; held at zero outside IDLE or when disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_cnt <= '0;
        end else if ((state != ST_IDLE) || (period == '0) || auto_trig) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + PERIOD_W'(1);
        end
    end
`else
    assign auto_trig = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_INIT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: bus states advance on transfer completion
    always_comb begin
        next_state = state;
        case (state)
            ST_INIT:    if (done) next_state = ST_IDLE;
            ST_IDLE:    if (trigger || pending || auto_trig) next_state = ST_SMP_SET;
            ST_SMP_SET: if (done) next_state = ST_SMP_CLR;
            ST_SMP_CLR: if (done) next_state = ST_RD_LO;
            ST_RD_LO:   if (done) next_state = ST_RD_HI;
            ST_RD_HI:   if (done) next_state = ST_DONE;
            ST_DONE:    next_state = ST_IDLE;
            default:    next_state = ST_INIT;
        endcase
    end

    // Output logic: bus request contents per state, status flags
    always_comb begin
        req         = is_bus_state(state);
        req_address = '0;
        req_wdata   = '0;
        req_wstrb   = '0;
        busy        = (state != ST_IDLE);
        ts_valid    = (state == ST_DONE);
        case (state)
            ST_INIT: begin
                req_address = ADDR_W'(ENABLE_ADDR);
                req_wdata   = DATA_W'(1);
                req_wstrb   = '1;
            end
            ST_SMP_SET: begin
                req_address = ADDR_W'(SAMPLE_ADDR);
                req_wdata   = DATA_W'(1);
                req_wstrb   = '1;
            end
            ST_SMP_CLR: begin
                req_address = ADDR_W'(SAMPLE_ADDR);
                req_wdata   = '0;
                req_wstrb   = '1;
            end
            ST_RD_LO: req_address = ADDR_W'(LOW_ADDR);
            ST_RD_HI: req_address = ADDR_W'(HIGH_ADDR);
            default: ;
        endcase
    end

    // Pending flag: coalesces triggers seen outside IDLE, cleared when a
    // sequence starts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
        end else if ((state == ST_IDLE) && (next_state == ST_SMP_SET)) begin
            pending <= 1'b0;
        end else if (trigger && (state != ST_IDLE)) begin
            pending <= 1'b1;
        end
    end

    // Capture registers: low half on RD_LO completion, full value on RD_HI
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            low_reg   <= '0;
            timestamp <= '0;
        end else if (done && (state == ST_RD_LO)) begin
            low_reg <= rdata;
        end else if (done && (state == ST_RD_HI)) begin
            timestamp <= {rdata, low_reg};
        end
    end

endmodule

// File: tb/tb_iob_timer_poller.sv
// Scoreboard bench for iob_timer_poller: stimulus pushes expected bus
// transfers and timestamps; a negedge monitor pops and compares them.
module tb_iob_timer_poller;

    logic        clk = 1'b0;
    logic        rst;
    logic        trigger;
    logic        valid;
    logic [15:0] address;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        ready;
    logic [63:0] timestamp;
    logic        ts_valid;
    logic        busy;
`ifdef TIMER_POLLER_PERIODIC_EN
    logic [15:0] period;
`endif

    iob_timer_poller dut (
        .clk       (clk),
        .rst       (rst),
`ifdef TIMER_POLLER_PERIODIC_EN
        .period    (period),
`endif
        .trigger   (trigger),
        .valid     (valid),
        .address   (address),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .rdata     (rdata),
        .ready     (ready),
        .timestamp (timestamp),
        .ts_valid  (ts_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } xfer_t;

    typedef struct {
        logic [63:0] ts;
        int          lat;
    } ts_exp_t;

    xfer_t   exp_x[$];
    ts_exp_t exp_t[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int trig_cyc = 0;
    int wait_mode = 0;
    int wcnt     = 0;
    logic [31:0] lo_val = '0;
    logic [31:0] hi_val = '0;

    task automatic chk(input string name, input bit ok,
                       input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    always @(posedge clk) cyc = cyc + 1;

    // Responder: ready every cycle, or 3 wait cycles per transfer
    always @(posedge clk) begin
        #1;
        if (rst) begin
            ready = 1'b0;
            wcnt  = 0;
        end else if (wait_mode == 0) begin
            ready = 1'b1;
        end else if (!valid) begin
            ready = 1'b0;
            wcnt  = 0;
        end else if (wcnt == 3) begin
            ready = 1'b1;
            wcnt  = 0;
        end else begin
            ready = 1'b0;
            wcnt  = wcnt + 1;
        end
        rdata = (address == 16'd3) ? lo_val : (address == 16'd4) ? hi_val : 32'h0;
    end

    // Monitor
    logic  prev_valid = 1'b0;
    logic  prev_ts    = 1'b0;
    xfer_t held;
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_ts    = 1'b0;
        end else begin
            if (valid) begin
                if (prev_valid)
                    chk("req_stable", {address, wdata, wstrb} == held,
                        64'({address, wdata, wstrb}), 64'(held));
                else
                    held = {address, wdata, wstrb};
            end
            if (valid && ready) begin
                if (exp_x.size() == 0) begin
                    chk("xfer_unexpected", 1'b0, 64'({address, wdata, wstrb}), 64'h0);
                end else begin
                    xfer_t e;
                    e = exp_x.pop_front();
                    chk("xfer", {address, wdata, wstrb} == e,
                        64'({address, wdata, wstrb}), 64'(e));
                end
            end
            if (ts_valid) begin
                chk("ts_pulse_width", !prev_ts, 64'(prev_ts), 64'h0);
                if (exp_t.size() == 0) begin
                    chk("ts_unexpected", 1'b0, timestamp, 64'h0);
                end else begin
                    ts_exp_t e;
                    e = exp_t.pop_front();
                    chk("timestamp", timestamp == e.ts, timestamp, e.ts);
                    if (e.lat >= 0)
                        chk("latency", (cyc - trig_cyc) == e.lat,
                            64'(cyc - trig_cyc), 64'(e.lat));
                end
            end
            prev_valid = valid;
            prev_ts    = ts_valid;
        end
    end

    task automatic push_seq(input logic [31:0] lo, input logic [31:0] hi, input int lat);
        ts_exp_t t;
        exp_x.push_back({16'd2, 32'd1, 4'hF});
        exp_x.push_back({16'd2, 32'd0, 4'hF});
        exp_x.push_back({16'd3, 32'd0, 4'h0});
        exp_x.push_back({16'd4, 32'd0, 4'h0});
        t.ts  = {hi, lo};
        t.lat = lat;
        exp_t.push_back(t);
    endtask

    task automatic pulse(input bit mark);
        @(posedge clk); #1;
        trigger = 1'b1;
        if (mark) trig_cyc = cyc;
        @(posedge clk); #1;
        trigger = 1'b0;
    endtask

    task automatic drain(input string name, input int max);
        int n = 0;
        while ((exp_x.size() != 0 || exp_t.size() != 0 || busy) && n < max) begin
            @(negedge clk);
            n++;
        end
        chk(name, exp_x.size() == 0 && exp_t.size() == 0 && !busy,
            64'(exp_x.size() + exp_t.size()), 64'h0);
    endtask

    initial begin
        rst     = 1'b1;
        trigger = 1'b0;
        ready   = 1'b0;
        rdata   = '0;
`ifdef TIMER_POLLER_PERIODIC_EN
        period  = '0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid",     valid == 1'b0,     64'(valid),     64'h0);
        chk("rst_address",   address == '0,     64'(address),   64'h0);
        chk("rst_wdata",     wdata == '0,       64'(wdata),     64'h0);
        chk("rst_wstrb",     wstrb == '0,       64'(wstrb),     64'h0);
        chk("rst_timestamp", timestamp == '0,   timestamp,      64'h0);
        chk("rst_ts_valid",  ts_valid == 1'b0,  64'(ts_valid),  64'h0);
        chk("rst_busy",      busy == 1'b1,      64'(busy),      64'h1);

        // Enable write after reset release
        exp_x.push_back({16'd1, 32'd1, 4'hF});
        @(posedge clk); #1;
        rst = 1'b0;
        drain("init_drain", 50);
        chk("idle_busy", busy == 1'b0, 64'(busy), 64'h0);

        // Single capture, zero wait
        lo_val = 32'hDEADBEEF;
        hi_val = 32'h00000012;
        push_seq(lo_val, hi_val, 9);
        pulse(1'b1);
        drain("cap0_drain", 60);
        repeat (5) @(negedge clk);
        chk("ts_hold", timestamp == 64'h00000012DEADBEEF, timestamp, 64'h00000012DEADBEEF);

        // Capture with 3 wait cycles per transfer
        wait_mode = 1;
        lo_val = 32'h11223344;
        hi_val = 32'hA5A5A5A5;
        push_seq(lo_val, hi_val, 21);
        pulse(1'b1);
        drain("cap_wait_drain", 120);

        // Triggers during an active sequence coalesce into one more
        lo_val = 32'h0BADF00D;
        hi_val = 32'h00000077;
        push_seq(lo_val, hi_val, 21);
        push_seq(lo_val, hi_val, -1);
        pulse(1'b1);
        for (int i = 0; i < 3; i++) begin
            repeat (3) @(posedge clk);
            pulse(1'b0);
        end
        drain("coalesce_drain", 200);
        repeat (40) @(negedge clk);
        chk("coalesce_quiet", exp_t.size() == 0 && !busy, 64'(busy), 64'h0);

        // Reset during RD_LO
        lo_val = 32'hCAFEF00D;
        hi_val = 32'h00000001;
        exp_x.push_back({16'd2, 32'd1, 4'hF});
        exp_x.push_back({16'd2, 32'd0, 4'hF});
        pulse(1'b0);
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(valid && address == 16'd3) && n < 100);
            chk("rdlo_reached", valid && address == 16'd3, 64'(address), 64'h3);
        end
        #2 rst = 1'b1;
        #1;
        chk("abort_valid",     valid == 1'b0,   64'(valid),   64'h0);
        chk("abort_timestamp", timestamp == '0, timestamp,    64'h0);
        chk("abort_busy",      busy == 1'b1,    64'(busy),    64'h1);
        chk("abort_pre_xfers", exp_x.size() == 0, 64'(exp_x.size()), 64'h0);
        exp_x.delete();
        exp_t.delete();
        repeat (2) @(posedge clk);
        exp_x.push_back({16'd1, 32'd1, 4'hF});
        #1 rst = 1'b0;
        drain("reinit_drain", 60);
        chk("reinit_ts_zero", timestamp == '0, timestamp, 64'h0);

`ifdef TIMER_POLLER_PERIODIC_EN
        // Auto-poll every period+9 cycles with ready always high
        begin
            int tcyc[3];
            wait_mode = 0;
            lo_val = 32'h01020304;
            hi_val = 32'h0A0B0C0D;
            repeat (3) push_seq(lo_val, hi_val, -1);
            @(posedge clk); #1;
            period = 16'd20;
            for (int k = 0; k < 3; k++) begin
                int n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!ts_valid && n < 100);
                chk("periodic_seen", ts_valid, 64'(ts_valid), 64'h1);
                tcyc[k] = cyc;
            end
            period = '0;
            chk("periodic_gap0", (tcyc[1] - tcyc[0]) == 29, 64'(tcyc[1] - tcyc[0]), 64'd29);
            chk("periodic_gap1", (tcyc[2] - tcyc[1]) == 29, 64'(tcyc[2] - tcyc[1]), 64'd29);
            repeat (80) @(negedge clk);
            chk("periodic_off", exp_x.size() == 0 && exp_t.size() == 0 && !busy,
                64'(exp_t.size()), 64'h0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
